// File: rtl/fetch_stage.sv
// Instruction-fetch stage of a 5-stage MIPS-style pipeline.
//
// This stage owns the program counter and presents it as the word address of an
// asynchronous-read instruction memory. The returned instruction is captured into
// the IF/ID pipeline register together with PC+1 and a valid bit. Stall, flush and
// redirect requests come from later stages. A counter tracks how many valid
// instructions have been delivered into IF/ID.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   stall         hold PC and IF/ID
//   flush         squash the instruction being captured this cycle
//   redirect      taken branch/jump; load PC from redirect_adr
//   redirect_adr  redirect target word address
//   inst_in       instruction memory read data; only [INST_W-1:0] is used
//   adr           fetch address, equal to the current PC
//   if_id_inst    registered instruction
//   if_id_pc1     registered PC+1 of that instruction
//   if_id_valid   IF/ID holds a real instruction (0 = bubble)
//   fetch_count   number of instructions delivered valid into IF/ID (wraps)
module fetch_stage #(
    parameter int unsigned             ADR_W    = 10,
    parameter int unsigned             INST_W   = 16,
    parameter logic [ADR_W-1:0]        RESET_PC = '0,
    parameter logic [INST_W-1:0]       NOP      = '0,
    parameter int unsigned             CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADR_W-1:0]  redirect_adr,
    input  logic [31:0]       inst_in,
    output logic [ADR_W-1:0]  adr,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADR_W-1:0]  if_id_pc1,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [ADR_W-1:0]  pc_q, pc_d, pc_inc;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADR_W-1:0]  pc1_q, pc1_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The upper instruction bits are deliberately ignored.
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst_in[31:INST_W];

    always_comb begin
        // Wraps modulo 2^ADR_W by construction.
        pc_inc  = pc_q + ADR_W'(1);
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (redirect) begin
            // Redirect beats stall and flush: the wrong-path slot becomes a bubble.
            pc_d    = redirect_adr;
            inst_d  = NOP;
            pc1_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            if (flush) begin
                inst_d  = NOP;
                pc1_d   = '0;
                valid_d = 1'b0;
            end
        end else if (flush) begin
            // The squashed slot still consumes its address.
            pc_d    = pc_inc;
            inst_d  = NOP;
            pc1_d   = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_inc;
            inst_d  = inst_in[INST_W-1:0];
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            pc1_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign adr         = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc1   = pc1_q;
    assign if_id_valid = valid_q;
    assign fetch_count = cnt_q;

endmodule
